bsg_manycore_store_credit_ctrl: RTL

//  Remote-store flow controller between the tile core's data port and the outbound store network.

---
 rtl/bsg_manycore_store_credit_pkg.sv | 12 +
 rtl/bsg_counter_up_down_sat.sv | 37 +++
 rtl/bsg_manycore_store_credit_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/bsg_manycore_store_credit_pkg.sv
// Shared types for the remote-store credit controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package bsg_manycore_store_credit_pkg;

  // RUN: stores flow subject to credit. FENCE_DRAIN: stores held until all acks return.
  typedef enum logic [0:0] {
    eRUN         = 1'b0,
    eFENCE_DRAIN = 1'b1
  } store_credit_state_e;

endpackage

// File: rtl/bsg_counter_up_down_sat.sv
// Saturating up/down counter, clamps at 0 and max_val_p; up and down together hold.
// Latency: count_o is registered, updates one cycle after up_i/down_i.
// Backpressure: none; requests past a limit are dropped (caller detects underflow).
// Ports: clk_i, reset_n_i (async active-low), up_i, down_i, count_o.
module bsg_counter_up_down_sat #(
  parameter int max_val_p = 16,
  parameter int width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i && (count_q != width_p'(max_val_p))) begin
      count_d = count_q + width_p'(1);
    end else if (down_i && !up_i && (count_q != '0)) begin
      count_d = count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_manycore_store_credit_ctrl.sv
// Remote-store credit/fence controller between the core data port and the store network.
// Latency: store handshake is combinational (0 cycles); fence completes >=1 cycle after request.
// Backpressure: net_v_o drops when credits run out or a fence is pending; acks always accepted.
// Ports: clk_i/reset_n_i; store_v_i/store_yumi_o (core), net_v_o/net_ready_i (network),
//        ret_v_i (acks), fence_v_i/fence_yumi_o/fence_data_o (fence), status outputs.
module bsg_manycore_store_credit_ctrl
  import bsg_manycore_store_credit_pkg::*;
#(
  parameter int max_credits_p   = 16,
  parameter int fence_timeout_p = 1024,
  parameter int data_width_p    = 32,
  localparam int cnt_width_lp   = $clog2(max_credits_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    store_v_i,
  output logic                    store_yumi_o,
  output logic                    net_v_o,
  input  logic                    net_ready_i,
  input  logic                    ret_v_i,
  input  logic                    fence_v_i,
  output logic                    fence_yumi_o,
  output logic [data_width_p-1:0] fence_data_o,
  output logic [cnt_width_lp-1:0] outstanding_o,
  output logic                    underflow_o,
  output logic                    timeout_o,
  output logic                    idle_o
);

  localparam int wd_width_lp = $clog2(fence_timeout_p + 1);
  localparam logic [wd_width_lp-1:0] wd_last_lp = wd_width_lp'(fence_timeout_p - 1);

  store_credit_state_e     state_d, state_q;
  logic [wd_width_lp-1:0]  watchdog_d, watchdog_q;
  logic                    underflow_d, underflow_q;
  logic                    timeout_d, timeout_q;
  logic [cnt_width_lp-1:0] count_r;
  logic                    credit_ok, in_run, cnt_zero, fire;

  // Credit check uses only the registered count: an ack arriving this cycle frees
  // a credit for next cycle, never for the store presented now.
  assign credit_ok = (count_r < cnt_width_lp'(max_credits_p));
  assign in_run    = (state_q == eRUN);
  assign cnt_zero  = (count_r == '0);

  // A fence request wins over a same-cycle store. Gating with reset keeps the
  // handshakes quiet while reset is held even if the core keeps requesting.
  assign net_v_o      = reset_n_i & store_v_i & credit_ok & in_run & ~fence_v_i;
  assign fire         = net_v_o & net_ready_i;
  assign store_yumi_o = fire;

  assign fence_yumi_o = reset_n_i & ~in_run & fence_v_i & cnt_zero;
  assign fence_data_o = fence_yumi_o ? data_width_p'(count_r) : '0;

  bsg_counter_up_down_sat #(
    .max_val_p (max_credits_p),
    .width_p   (cnt_width_lp)
  ) outstanding_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .up_i      (fire),
    .down_i    (ret_v_i),
    .count_o   (count_r)
  );

  always_comb begin
    state_d    = state_q;
    watchdog_d = watchdog_q;
    timeout_d  = timeout_q;
    // An ack with nothing outstanding (and no store to cancel it) is a protocol error.
    underflow_d = underflow_q | (ret_v_i & ~fire & cnt_zero);

    case (state_q)
      eRUN: begin
        if (fence_v_i) begin
          state_d    = eFENCE_DRAIN;
          watchdog_d = '0;
        end
      end
      eFENCE_DRAIN: begin
        // Watchdog parks at its last value so it cannot wrap during a long drain.
        if (watchdog_q == wd_last_lp) begin
          timeout_d = 1'b1;
        end else begin
          watchdog_d = watchdog_q + wd_width_lp'(1);
        end
        // Leave on completion, or when the core abandons the fence.
        if (!fence_v_i || cnt_zero) begin
          state_d = eRUN;
        end
      end
      default: state_d = eRUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= eRUN;
      watchdog_q  <= '0;
      underflow_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      watchdog_q  <= watchdog_d;
      underflow_q <= underflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign outstanding_o = count_r;
  assign underflow_o   = underflow_q;
  assign timeout_o     = timeout_q;
  assign idle_o        = cnt_zero & in_run;

endmodule
